// File: rtl/rgb_led_arbiter.sv
// Two-requester, frame-synchronous owner arbiter for an RGB LED.
// Each channel is driven by PWM at a steady level or at a level scaled by a triangle "breathe" envelope.
module rgb_led_arbiter #(
   parameter int unsigned STEP_DIV = 300000
) (
   input  logic        clki,
   input  logic        rst,
   input  logic [1:0]  req,
   input  logic [23:0] colour0,
   input  logic [23:0] colour1,
   input  logic [1:0]  mode,
   output logic [1:0]  gnt,
   output logic        pwm_r,
   output logic        pwm_g,
   output logic        pwm_b,
   output logic        frame
);

   typedef enum logic [1:0] {IDLE = 2'b00, OWN0 = 2'b01, OWN1 = 2'b10} state_t;

   localparam logic [23:0] STEP_LAST = 24'(STEP_DIV - 1);

   state_t          state_q, state_d;
   logic [7:0]      pwm_cnt;
   logic            boundary;
   logic            owner_chg;
   logic [23:0]     step_cnt;
   logic [7:0]      env;
   logic            dir;
   logic [2:0][7:0] lat_col;
   logic            lat_mode;
   logic [23:0]     nxt_col;
   logic            nxt_mode;
   logic [2:0][7:0] lvl;
   logic [2:0]      pwm_vec;

   assign boundary  = (pwm_cnt == 8'hFF);
   assign owner_chg = (state_d != state_q);
   assign gnt       = state_q;

   // The owner is kept while its req is high; otherwise the lowest index wins.
   always_comb begin
      state_d = state_q;
      if (boundary) begin
         case (state_q)
            OWN0:    if (!req[0]) state_d = req[1] ? OWN1 : IDLE;
            OWN1:    if (!req[1]) state_d = req[0] ? OWN0 : IDLE;
            default: state_d = req[0] ? OWN0 : (req[1] ? OWN1 : IDLE);
         endcase
      end
      nxt_col  = 24'h0;
      nxt_mode = 1'b0;
      case (state_d)
         OWN0:    begin nxt_col = colour0; nxt_mode = mode[0]; end
         OWN1:    begin nxt_col = colour1; nxt_mode = mode[1]; end
         default: ;
      endcase
   end

   always_ff @(posedge clki) begin
      if (rst) begin
         state_q  <= IDLE;
         pwm_cnt  <= 8'h0;
         frame    <= 1'b0;
         lat_col  <= '0;
         lat_mode <= 1'b0;
      end else begin
         state_q <= state_d;
         pwm_cnt <= pwm_cnt + 8'd1;
         frame   <= (pwm_cnt == 8'd254);
         if (boundary) begin
            lat_col  <= nxt_col;
            lat_mode <= nxt_mode;
         end
      end
   end

   // Envelope restarts from zero whenever the owner changes.
   always_ff @(posedge clki) begin
      if (rst || (boundary && owner_chg)) begin
         step_cnt <= 24'h0;
         env      <= 8'h0;
         dir      <= 1'b0;
      end else if (step_cnt == STEP_LAST) begin
         step_cnt <= 24'h0;
         if (!dir) begin
            if (env == 8'hFF) begin
               dir <= 1'b1;
               env <= 8'hFE;
            end else begin
               env <= env + 8'd1;
            end
         end else begin
            if (env == 8'h00) begin
               dir <= 1'b0;
               env <= 8'h01;
            end else begin
               env <= env - 8'd1;
            end
         end
      end else begin
         step_cnt <= step_cnt + 24'd1;
      end
   end

   for (genvar c = 0; c < 3; c++) begin : g_lane
      assign lvl[c] = lat_mode ? 8'((16'(lat_col[c]) * 16'(env)) >> 8) : lat_col[c];
   end

   always_ff @(posedge clki) begin
      if (rst) begin
         pwm_vec <= 3'b000;
      end else begin
         for (int c = 0; c < 3; c++)
            pwm_vec[c] <= (state_q != IDLE) && (pwm_cnt < lvl[c]);
      end
   end

   assign {pwm_r, pwm_g, pwm_b} = pwm_vec;

endmodule

// File: tb/tb_rgb_led_arbiter.sv
// Bench for rgb_led_arbiter: directed phases plus a random phase, all checked per cycle against a frame-level model.
module tb_rgb_led_arbiter;

   localparam int STEP = 4;

   logic        clki = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  req = 2'b00;
   logic [23:0] colour0 = 24'h0;
   logic [23:0] colour1 = 24'h0;
   logic [1:0]  mode = 2'b00;
   logic [1:0]  gnt;
   logic        pwm_r, pwm_g, pwm_b, frame;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state: frame position, owner (0 idle, 1, 2), cycles since ownership began
   int          m_cnt = 0;
   int          m_own = 0;
   int          m_t   = 0;
   logic [23:0] m_col = 24'h0;
   logic        m_mode = 1'b0;
   logic [2:0]  m_pwm = 3'b000;

   rgb_led_arbiter #(.STEP_DIV(STEP)) dut (
      .clki(clki), .rst(rst), .req(req), .colour0(colour0), .colour1(colour1),
      .mode(mode), .gnt(gnt), .pwm_r(pwm_r), .pwm_g(pwm_g), .pwm_b(pwm_b), .frame(frame)
   );

   always #5 clki = ~clki;

   // Triangle envelope: 0 up to 255, back down to 0, period 510 steps
   function automatic int env_at(input int t);
      int k;
      k = (t / STEP) % 510;
      return (k <= 255) ? k : 510 - k;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Advance the model across the coming edge (inputs as now driven), then check outputs mid-cycle.
   task automatic tick();
      int env, col_c, lvl, nxt;
      if (rst) begin
         m_cnt = 0; m_own = 0; m_t = 0; m_col = 24'h0; m_mode = 1'b0; m_pwm = 3'b000;
      end else begin
         env = env_at(m_t);
         for (int c = 0; c < 3; c++) begin
            col_c = int'(m_col[8*c +: 8]);
            lvl = m_mode ? (col_c * env) / 256 : col_c;
            m_pwm[c] = (m_own != 0) && (m_cnt < lvl);
         end
         if (m_cnt == 255) begin
            if (m_own == 1 && req[0])      nxt = 1;
            else if (m_own == 2 && req[1]) nxt = 2;
            else if (req[0])               nxt = 1;
            else if (req[1])               nxt = 2;
            else                           nxt = 0;
            m_t   = (nxt != m_own) ? 0 : m_t + 1;
            m_own = nxt;
            m_col  = (nxt == 1) ? colour0 : (nxt == 2) ? colour1 : 24'h0;
            m_mode = (nxt == 1) ? mode[0] : (nxt == 2) ? mode[1] : 1'b0;
         end else begin
            m_t++;
         end
         m_cnt = (m_cnt + 1) % 256;
      end
      @(negedge clki);
      chk("gnt", 32'(gnt), (m_own == 0) ? 32'd0 : 32'(1 << (m_own - 1)));
      chk("frame", 32'(frame), 32'(m_cnt == 255));
      chk("pwm_rgb", 32'({pwm_r, pwm_g, pwm_b}), 32'(m_pwm));
   endtask

   task automatic run_to(input int target);
      int k;
      k = 0;
      while (m_cnt != target && k < 300) begin
         tick();
         k++;
      end
      if (m_cnt != target) begin
         n_tests++;
         n_fail++;
         $display("FAIL run_to_timeout got=%0d exp=%0d", m_cnt, target);
      end
   endtask

   initial begin
      int hr, hg, hb, nf;

      // Reset
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;

      // Idle: no grant, no PWM, a frame pulse every 256 clocks
      hr = 0; nf = 0;
      repeat (512) begin
         tick();
         hr += int'(pwm_r | pwm_g | pwm_b);
         nf += int'(frame);
      end
      chk("idle_pwm_count", 32'(hr), 32'd0);
      chk("idle_frame_count", 32'(nf), 32'd2);

      // Steady red on requester 0: grant at next frame, red high 255/256
      req = 2'b01; colour0 = 24'hFF0000; mode = 2'b00;
      repeat (255) tick();
      chk("grant_wait", 32'(gnt), 32'd0);
      tick();
      chk("grant_own0", 32'(gnt), 32'd1);
      hr = 0; hg = 0; hb = 0;
      repeat (256) begin
         tick();
         hr += int'(pwm_r); hg += int'(pwm_g); hb += int'(pwm_b);
      end
      chk("red_duty", 32'(hr), 32'd255);
      chk("green_duty", 32'(hg), 32'd0);
      chk("blue_duty", 32'(hb), 32'd0);

      // Non-preemption: owner 1 keeps the grant while req[1] stays high
      req = 2'b10; colour1 = 24'h00FF40;
      run_to(255);
      tick();
      chk("own1", 32'(gnt), 32'd2);
      run_to(100);
      req = 2'b11;
      repeat (600) tick();
      chk("no_preempt", 32'(gnt), 32'd2);
      run_to(77);
      req = 2'b01;
      run_to(255);
      chk("hold_to_boundary", 32'(gnt), 32'd2);
      tick();
      chk("handover_own0", 32'(gnt), 32'd1);

      // Breathe on requester 0, entered from idle so the envelope starts at 0
      req = 2'b00;
      run_to(255);
      tick();
      chk("back_idle", 32'(gnt), 32'd0);
      colour0 = 24'h808080; mode = 2'b01; req = 2'b01;
      run_to(255);
      tick();
      repeat (1300) tick();

      // Colour change mid-frame only applies from the next frame
      mode = 2'b00; colour0 = 24'hFF0000;
      run_to(255);
      tick();
      run_to(50);
      colour0 = 24'h100000;
      run_to(200);
      chk("midframe_hold", 32'(pwm_r), 32'd1);
      run_to(255);
      tick();
      run_to(10);
      chk("newlvl_low_cnt", 32'(pwm_r), 32'd1);
      run_to(20);
      chk("newlvl_high_cnt", 32'(pwm_r), 32'd0);

      // Reset mid-grant
      run_to(100);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_pwm", 32'({pwm_r, pwm_g, pwm_b}), 32'd0);
      chk("rst_frame", 32'(frame), 32'd0);
      repeat (255) tick();
      chk("rst_first_frame", 32'(frame), 32'd1);
      chk("rst_still_idle", 32'(gnt), 32'd0);
      tick();
      chk("rst_regrant", 32'(gnt), 32'd1);

      // Random traffic
      for (int i = 0; i < 6000; i++) begin
         if ($urandom_range(0, 63) == 0)   req = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 31) == 0)   colour0 = 24'($urandom);
         if ($urandom_range(0, 31) == 0)   colour1 = 24'($urandom);
         if ($urandom_range(0, 127) == 0)  mode = 2'($urandom_range(0, 3));
         rst = ($urandom_range(0, 1499) == 0);
         tick();
      end
      rst = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/rgb_led_arbiter.md
RGB_LED_ARBITER -- requirements
Module: rgb_led_arbiter

Interface
REQ-001 The block SHALL have parameter STEP_DIV, default 300000: clocks per breathe-envelope step, legal range 1 to 2^24-1.
REQ-002 The block SHALL have port clki, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port req, input, 2 bits: per-requester LED-use request; req[0] has highest priority.
REQ-005 The block SHALL have port colour0, input, 24 bits: requester 0 level as {R[23:16], G[15:8], B[7:0]}.
REQ-006 The block SHALL have port colour1, input, 24 bits: requester 1 level, same packing as colour0.
REQ-007 The block SHALL have port mode, input, 2 bits: mode[i] selects the mode for requester i; 0 = steady, 1 = breathe.
REQ-008 The block SHALL have port gnt, output, 2 bits: one-hot current owner, or 0 when idle.
REQ-009 The block SHALL have port pwm_r, output, 1 bit: registered PWM enable for the red input of SB_RGBA_DRV.
REQ-010 The block SHALL have port pwm_g, output, 1 bit: registered PWM enable for the green input of SB_RGBA_DRV.
REQ-011 The block SHALL have port pwm_b, output, 1 bit: registered PWM enable for the blue input of SB_RGBA_DRV.
REQ-012 The block SHALL have port frame, output, 1 bit: one-cycle pulse in the cycle where pwm_cnt == 255.

Function
REQ-013 The block SHALL run an 8-bit free-running counter pwm_cnt, incrementing every clock and wrapping from 255 to 0; one frame is 256 clocks.
REQ-014 The arbiter SHALL have three states: IDLE, OWN0 and OWN1, with gnt = 00, 01 and 10 respectively.
REQ-015 The arbiter SHALL evaluate state transitions only in the frame-boundary cycle (pwm_cnt == 255); new state and gnt SHALL take effect in the cycle pwm_cnt == 0.
REQ-016 Arbitration SHALL be non-preemptive: an owner whose req bit is still high at a boundary SHALL keep the grant, even if a higher-priority req is present.
REQ-017 If the owner's req bit is low at a boundary, the next state SHALL be OWN0 if req[0]=1, else OWN1 if req[1]=1, else IDLE.
REQ-018 A req pulse that starts and ends entirely between two boundaries SHALL be ignored.
REQ-019 At each boundary the block SHALL latch the colour and mode of the next owner into lat_col[23:0] and lat_mode; these SHALL be held constant for the whole following frame.
REQ-020 In IDLE, lat_col SHALL be latched as 0.
REQ-021 The breathe envelope SHALL use env[7:0], a direction bit dir (0 = up) and a step counter step_cnt.
REQ-022 step_cnt SHALL count from 0 to STEP_DIV-1 and wrap to 0; env SHALL update only in the cycle where step_cnt == STEP_DIV-1.
REQ-023 On an env update with dir=0: if env == 255, dir SHALL be set to 1 and env SHALL become 254; otherwise env SHALL increment.
REQ-024 On an env update with dir=1: if env == 0, dir SHALL be set to 0 and env SHALL become 1; otherwise env SHALL decrement.
REQ-025 The breathe period SHALL therefore be 510 steps.
REQ-026 Whenever a boundary changes the owner (including to or from IDLE), env, dir and step_cnt SHALL be cleared to 0 in the same update.
REQ-027 For each channel c, the level SHALL be lvl_c = lat_col_c when lat_mode = 0.
REQ-028 For each channel c, when lat_mode = 1 the level SHALL be lvl_c = (lat_col_c * env) >> 8, computed as a 16-bit product with bits [15:8] taken and no rounding.
REQ-029 Each pwm_c SHALL equal the registered value of (pwm_cnt < lvl_c), giving one clock of latency from pwm_cnt.
REQ-030 As a consequence of REQ-029, a level of 0 SHALL give a constant 0, and a level of 255 SHALL be high for 255 of every 256 clocks.
REQ-031 When gnt == 00, pwm_r, pwm_g and pwm_b SHALL all be 0.

Reset
REQ-032 While rst=1 at a clock edge, the block SHALL clear pwm_cnt, step_cnt, env, dir, lat_col, lat_mode, gnt, pwm_r/g/b and frame to 0, and SHALL enter IDLE.
REQ-033 Reset asserted mid-frame or mid-grant SHALL take effect on the next edge with no frame completion.
REQ-034 After rst deasserts, the first boundary SHALL occur 256 clocks later.

Verification
REQ-035 With STEP_DIV=4: req=01, colour0=FF0000, mode=0 after reset -> gnt=01 from cycle 256; pwm_r high 255 of 256 clocks per frame; pwm_g and pwm_b stay 0.
REQ-036 Owner 1 steady and then req[0] rises mid-frame with req[1] held -> gnt stays 10; after req[1] drops, gnt becomes 01 exactly at the next pwm_cnt == 0.
REQ-037 Breathe test, colour0=808080, STEP_DIV=4 -> env reaches 255 after 1020 clocks, then 254; duty per channel = (128*env)>>8 clocks per frame.
REQ-038 colour0 changed mid-frame -> pwm duty changes only from the next frame; no glitch within the current frame.
REQ-039 rst pulsed for one cycle at pwm_cnt=100 while in OWN0 -> the next cycle shows all outputs 0 and IDLE, and pwm_cnt restarts at 0.
REQ-040 req=00 throughout -> gnt=00 and all pwm outputs 0 indefinitely; frame pulses every 256 clocks.
